fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the control decoder.
- Holds the program counter, addresses the combinational instruction ROM, and registers the 9-bit instruction presented to the decoder.
- Resolves taken branches using an 8-entry loadable branch-target lookup table, since the 9-bit ISA cannot encode full targets.
- Provides start/halt sequencing, stall hold and a run-cycle counter.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM, registers
// the 9-bit instruction for the decoder and resolves taken branches through an
// 8-entry loadable target/offset table.
module fetch_unit #(
    parameter int unsigned PC_W    = 10,
    parameter logic [8:0]  HALT_OP = 9'h0FF
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic [PC_W-1:0] i_start_addr,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic            i_branch_abs,
    input  logic [2:0]      i_lut_idx,
    input  logic            i_lut_we,
    input  logic [2:0]      i_lut_waddr,
    input  logic [PC_W-1:0] i_lut_wdata,
    input  logic [8:0]      i_instr_data,
    output logic [PC_W-1:0] o_instr_addr,
    output logic [8:0]      o_instruction,
    output logic            o_instr_valid,
    output logic [PC_W-1:0] o_instr_pc,
    output logic            o_halted,
    output logic [15:0]     o_cycle_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [8:0]      r_instr;
    logic            r_valid;
    logic [PC_W-1:0] r_instr_pc;
    logic            r_halted;
    logic [15:0]     r_cycle_count;
    logic [PC_W-1:0] r_lut [8];

    state_t          w_state_d;
    logic [PC_W-1:0] w_pc_d;
    logic [8:0]      w_instr_d;
    logic            w_valid_d;
    logic [PC_W-1:0] w_instr_pc_d;
    logic            w_halted_d;
    logic [15:0]     w_cycle_count_d;

    logic [PC_W-1:0] w_lut_rd;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;
    logic [15:0]     w_cnt_inc;

    // Branch target and saturating/wrapping increments.
    always_comb begin
        w_lut_rd  = r_lut[i_lut_idx];
        // Relative offsets are two's complement; a plain PC_W-bit add wraps correctly.
        w_target  = i_branch_abs ? w_lut_rd : (r_instr_pc + w_lut_rd);
        w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
        w_cnt_inc = (r_cycle_count == 16'hFFFF) ? r_cycle_count : (r_cycle_count + 16'd1);
    end

    // Next-state logic for the fetch sequencer and its datapath registers.
    always_comb begin
        w_state_d       = r_state;
        w_pc_d          = r_pc;
        w_instr_d       = r_instr;
        w_valid_d       = r_valid;
        w_instr_pc_d    = r_instr_pc;
        w_halted_d      = r_halted;
        w_cycle_count_d = r_cycle_count;

        unique case (r_state)
            StIdle, StHalted: begin
                w_valid_d = 1'b0;
                if (i_start) begin
                    w_state_d       = StRun;
                    w_pc_d          = i_start_addr;
                    w_cycle_count_d = 16'd0;
                    w_halted_d      = 1'b0;
                end
            end
            StRun: begin
                w_cycle_count_d = w_cnt_inc;
                if (!i_stall) begin
                    if (r_valid && (r_instr == HALT_OP)) begin
                        w_state_d  = StHalted;
                        w_halted_d = 1'b1;
                        w_valid_d  = 1'b0;
                    end else if (r_valid && i_branch_taken) begin
                        // The ROM word at the old PC is wrong-path; drop it (one bubble).
                        w_pc_d    = w_target;
                        w_valid_d = 1'b0;
                    end else begin
                        w_instr_d    = i_instr_data;
                        w_instr_pc_d = r_pc;
                        w_valid_d    = 1'b1;
                        w_pc_d       = w_pc_inc;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_valid_d = 1'b0;
            end
        endcase
    end

    // Fetch state and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_pc          <= '0;
            r_instr       <= '0;
            r_valid       <= 1'b0;
            r_instr_pc    <= '0;
            r_halted      <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_instr       <= w_instr_d;
            r_valid       <= w_valid_d;
            r_instr_pc    <= w_instr_pc_d;
            r_halted      <= w_halted_d;
            r_cycle_count <= w_cycle_count_d;
        end
    end

    // Branch table writes; a same-cycle branch reads the pre-write value.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 8; i++) begin
                r_lut[i] <= '0;
            end
        end else if (i_lut_we) begin
            r_lut[i_lut_waddr] <= i_lut_wdata;
        end
    end

    assign o_instr_addr  = r_pc;
    assign o_instruction = r_instr;
    assign o_instr_valid = r_valid;
    assign o_instr_pc    = r_instr_pc;
    assign o_halted      = r_halted;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus pushes expected (pc, instruction)
// pairs, a negedge monitor pops one for every instruction the decoder consumes.
module tb_fetch_unit;

    localparam logic [8:0] HALT = 9'h0FF;

    typedef struct packed {
        logic [9:0] pc;
        logic [8:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] start_addr;
    logic       stall;
    logic       branch_taken;
    logic       branch_abs;
    logic [2:0] lut_idx;
    logic       lut_we;
    logic [2:0] lut_waddr;
    logic [9:0] lut_wdata;
    logic [8:0] instr_data;
    logic [9:0] instr_addr;
    logic [8:0] instruction;
    logic       instr_valid;
    logic [9:0] instr_pc;
    logic       halted;
    logic [15:0] cycle_count;

    logic [8:0] rom [1024];
    exp_t       q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [15:0] cc_mark;

    fetch_unit #(
        .PC_W    (10),
        .HALT_OP (HALT)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_start        (start),
        .i_start_addr   (start_addr),
        .i_stall        (stall),
        .i_branch_taken (branch_taken),
        .i_branch_abs   (branch_abs),
        .i_lut_idx      (lut_idx),
        .i_lut_we       (lut_we),
        .i_lut_waddr    (lut_waddr),
        .i_lut_wdata    (lut_wdata),
        .i_instr_data   (instr_data),
        .o_instr_addr   (instr_addr),
        .o_instruction  (instruction),
        .o_instr_valid  (instr_valid),
        .o_instr_pc     (instr_pc),
        .o_halted       (halted),
        .o_cycle_count  (cycle_count)
    );

    assign instr_data = rom[instr_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [9:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = rom[pc];
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input logic [2:0] idx, input logic [9:0] data);
        lut_we    = 1'b1;
        lut_waddr = idx;
        lut_wdata = data;
        tick();
        lut_we    = 1'b0;
    endtask

    task automatic branch(input logic abs, input logic [2:0] idx);
        branch_taken = 1'b1;
        branch_abs   = abs;
        lut_idx      = idx;
    endtask

    // Monitor: an instruction is consumed when valid and not stalled at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && instr_valid && !stall) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL monitor: unexpected instruction at pc 0x%0h (none expected)",
                         instr_pc);
            end else begin
                e = q.pop_front();
                check("mon_instr_pc", instr_pc, e.pc);
                check("mon_instruction", instruction, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
        $fatal(1);
    end

    initial begin
        // Incrementing ROM contents, with the only HALT word placed at 0x020.
        for (int a = 0; a < 1024; a++) begin
            rom[a] = a[8:0];
            if (rom[a] == HALT) rom[a] = 9'h155;
        end
        rom[10'h020] = HALT;

        rst_n = 1'b1; start = 1'b0; start_addr = '0; stall = 1'b0;
        branch_taken = 1'b0; branch_abs = 1'b0; lut_idx = '0;
        lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        #3 rst_n = 1'b0;
        #10;
        check("rst_valid", instr_valid, 0);
        check("rst_pc", instr_addr, 0);
        check("rst_instr", instruction, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_halted", halted, 0);
        check("rst_cc", cycle_count, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("idle_valid", instr_valid, 0);

        lut_write(3'd3, 10'h040);
        lut_write(3'd5, 10'h3FE);
        lut_write(3'd1, 10'h01E);

        // Start at 0x010, sequential fetch.
        start = 1'b1; start_addr = 10'h010;
        push(10'h010);
        tick();
        start = 1'b0;
        check("start_valid0", instr_valid, 0);
        check("start_pc", instr_addr, 10'h010);
        check("start_cc0", cycle_count, 0);
        push(10'h011);
        tick();
        check("first_valid", instr_valid, 1);
        check("cc_run1", cycle_count, 1);
        push(10'h012);
        tick();
        tick();
        check("seq_instr_pc", instr_pc, 10'h012);

        // Absolute branch to LUT[3].
        branch(1'b1, 3'd3);
        push(10'h040);
        tick();
        branch_taken = 1'b0;
        check("abs_bubble", instr_valid, 0);
        check("abs_target", instr_addr, 10'h040);
        tick();
        check("abs_valid", instr_valid, 1);

        // Branch via LUT[0] while writing LUT[0]: the old value (0) must win.
        branch(1'b1, 3'd0);
        lut_we = 1'b1; lut_waddr = 3'd0; lut_wdata = 10'h123;
        push(10'h000);
        tick();
        branch_taken = 1'b0; lut_we = 1'b0;
        check("wr_br_old_value", instr_addr, 10'h000);
        check("wr_br_bubble", instr_valid, 0);
        push(10'h001);
        start = 1'b1; start_addr = 10'h155;  // ignored while running
        tick();
        start = 1'b0;
        tick();
        check("run_start_ignored", instr_pc, 10'h001);

        // Relative branch: 0x001 + (-2) = 0x3FF, then wrap to 0x000.
        branch(1'b0, 3'd5);
        push(10'h3FF);
        tick();
        branch_taken = 1'b0;
        check("rel_target", instr_addr, 10'h3FF);
        check("rel_bubble", instr_valid, 0);
        push(10'h000);
        tick();
        check("pc_wrap", instr_addr, 10'h000);
        tick();

        // Stall for 3 cycles with a branch pending.
        stall = 1'b1;
        branch(1'b1, 3'd3);
        cc_mark = cycle_count;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr_pc", instr_pc, 10'h000);
            check("stall_valid", instr_valid, 1);
            check("stall_pc", instr_addr, 10'h001);
        end
        check("stall_cc", cycle_count, 32'(cc_mark) + 3);
        stall = 1'b0;
        push(10'h040);
        tick();
        branch_taken = 1'b0;
        check("post_stall_bubble", instr_valid, 0);
        check("post_stall_target", instr_addr, 10'h040);
        tick();

        // Run into the HALT word at 0x020.
        branch(1'b1, 3'd1);
        push(10'h01E);
        tick();
        branch_taken = 1'b0;
        push(10'h01F);
        tick();
        push(10'h020);
        tick();
        tick();
        check("halt_presented", instruction, HALT);
        tick();
        check("halted", halted, 1);
        check("halt_valid", instr_valid, 0);
        check("halt_pc_hold", instr_addr, 10'h021);
        cc_mark = cycle_count;
        tick();
        tick();
        check("halt_cc_frozen", cycle_count, 32'(cc_mark));
        check("halt_valid_hold", instr_valid, 0);

        // Restart from HALTED.
        start = 1'b1; start_addr = 10'h000;
        push(10'h000);
        tick();
        start = 1'b0;
        check("restart_halted", halted, 0);
        check("restart_cc", cycle_count, 0);
        push(10'h001);
        tick();
        tick();
        check("restart_cc2", cycle_count, 2);

        // Asynchronous reset mid-run.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_pc", instr_addr, 0);
        check("arst_instr", instruction, 0);
        check("arst_instr_pc", instr_pc, 0);
        check("arst_cc", cycle_count, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("arst_idle", instr_valid, 0);

        // LUT[3] was cleared: the branch must now target 0.
        start = 1'b1; start_addr = 10'h010;
        push(10'h010);
        tick();
        start = 1'b0;
        tick();
        branch(1'b1, 3'd3);
        push(10'h000);
        tick();
        branch_taken = 1'b0;
        check("lut_cleared", instr_addr, 10'h000);
        tick();
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
